// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared ALU ops, FSM states, opcodes and the decoded control word
package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} ctrl_state_t;
  typedef enum logic [3:0] {
    C_ALU, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_LW, C_SW, C_LL, C_SC, C_HALT
  } iclass_t;
  typedef struct packed {
    iclass_t    cls;
    aluop_t     alu_op;
    logic [1:0] portb_src;
    logic       ext_src;
    logic       lui_src;
    logic       rtype;
    logic       check_over;
  } ctrl_word_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LL    = 6'b110000;
  localparam logic [5:0] OP_SC    = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_XOR    = 6'b100110;
  localparam logic [5:0] F_NOR    = 6'b100111;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_SLTU   = 6'b101011;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode/funct to control word decoder with illegal flag
module control_decode
  import cpu_types_pkg::*;
#(
  parameter int ATOMIC_EN = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_word_t cw,
  output logic       illegal
);
  // I-type ALU ops take the immediate on port b; sign-extension only for arithmetic/compare forms
  always_comb begin
    cw = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        cw.rtype = 1'b1;
        case (fn)
          F_SLL:  begin cw.alu_op = ALU_SLL; cw.portb_src = 2'b10; end
          F_SRL:  begin cw.alu_op = ALU_SRL; cw.portb_src = 2'b10; end
          F_JR:   cw.cls = C_JR;
          F_ADD:  begin cw.alu_op = ALU_ADD; cw.check_over = 1'b1; end
          F_ADDU: cw.alu_op = ALU_ADD;
          F_SUB:  begin cw.alu_op = ALU_SUB; cw.check_over = 1'b1; end
          F_SUBU: cw.alu_op = ALU_SUB;
          F_AND:  cw.alu_op = ALU_AND;
          F_OR:   cw.alu_op = ALU_OR;
          F_XOR:  cw.alu_op = ALU_XOR;
          F_NOR:  cw.alu_op = ALU_NOR;
          F_SLT:  cw.alu_op = ALU_SLT;
          F_SLTU: cw.alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_J:     cw.cls = C_J;
      OP_JAL:   cw.cls = C_JAL;
      OP_BEQ:   begin cw.cls = C_BEQ; cw.alu_op = ALU_SUB; end
      OP_BNE:   begin cw.cls = C_BNE; cw.alu_op = ALU_SUB; end
      OP_ADDI:  begin cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; cw.check_over = 1'b1; end
      OP_ADDIU: begin cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; end
      OP_SLTI:  begin cw.alu_op = ALU_SLT; cw.portb_src = 2'b01; cw.ext_src = 1'b1; end
      OP_SLTIU: begin cw.alu_op = ALU_SLTU; cw.portb_src = 2'b01; cw.ext_src = 1'b1; end
      OP_ANDI:  begin cw.alu_op = ALU_AND; cw.portb_src = 2'b01; end
      OP_ORI:   begin cw.alu_op = ALU_OR; cw.portb_src = 2'b01; end
      OP_XORI:  begin cw.alu_op = ALU_XOR; cw.portb_src = 2'b01; end
      OP_LUI:   begin cw.alu_op = ALU_OR; cw.portb_src = 2'b01; cw.lui_src = 1'b1; end
      OP_LW:    begin cw.cls = C_LW; cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; end
      OP_SW:    begin cw.cls = C_SW; cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; end
      OP_LL:    begin cw.cls = C_LL; cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; illegal = (ATOMIC_EN == 0); end
      OP_SC:    begin cw.cls = C_SC; cw.alu_op = ALU_ADD; cw.portb_src = 2'b01; cw.ext_src = 1'b1; illegal = (ATOMIC_EN == 0); end
      OP_HALT:  cw.cls = C_HALT;
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout, overflow trap and sticky halt/err
module multicycle_control_fsm
  import cpu_types_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int ATOMIC_EN   = 1,
  parameter int OVF_TRAP    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        zero,
  input  logic        overflow,
  output logic [1:0]  PC_src,
  output logic        PC_EN,
  output logic        IR_EN,
  output logic        Ext_src,
  output logic        LUI_src,
  output logic [1:0]  portb_src,
  output logic [1:0]  RegDst,
  output aluop_t      ALU_op,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        datomic,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic        check_over,
  output logic        exc,
  output logic        halt,
  output logic        err,
  output logic [2:0]  state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  ctrl_state_t    cur, nxt;
  ctrl_word_t     cw_q, dec_cw;
  logic           dec_illegal, timeout, trap, unused_bits;
  logic [11:0]    ir_q;
  logic [CW-1:0]  cnt;
  assign unused_bits = ^instr[25:6];
  assign timeout = cnt == CW'(MEM_TIMEOUT - 1);
  assign trap = (OVF_TRAP != 0) && cw_q.check_over && overflow;
  assign state = RST ? 3'd0 : cur;
  assign halt = !RST && cur == HALT;
  assign err = !RST && cur == ERR;
  control_decode #(.ATOMIC_EN(ATOMIC_EN)) u_dec (
    .op(ir_q[11:6]),
    .fn(ir_q[5:0]),
    .cw(dec_cw),
    .illegal(dec_illegal)
  );
  // state, IR (opcode+funct only), latched control word and wait counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur <= FETCH;
      ir_q <= '0;
      cw_q <= '0;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (IR_EN) ir_q <= {instr[31:26], instr[5:0]};
      if (cur == DECODE) cw_q <= dec_cw;
      cnt <= (nxt != cur || !(cur inside {FETCH, MEM})) ? '0 : cnt + 1'b1;
    end
  end
  // next state and strobes; everything held low while reset is asserted
  always_comb begin
    nxt = cur;
    PC_src = 2'b00;
    PC_EN = 1'b0;
    IR_EN = 1'b0;
    Ext_src = 1'b0;
    LUI_src = 1'b0;
    portb_src = 2'b00;
    RegDst = 2'b00;
    ALU_op = ALU_SLL;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    datomic = 1'b0;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    check_over = 1'b0;
    exc = 1'b0;
    if (!RST && cur inside {EXEC, MEM, WB}) begin
      ALU_op = cw_q.alu_op;
      portb_src = cw_q.portb_src;
      Ext_src = cw_q.ext_src;
      LUI_src = cw_q.lui_src;
      check_over = cw_q.check_over;
    end
    if (!RST) begin
      case (cur)
        FETCH: begin
          iREN = 1'b1;
          IR_EN = ihit;
          PC_EN = ihit;
          nxt = ihit ? DECODE : timeout ? ERR : FETCH;
        end
        DECODE: nxt = dec_illegal ? ERR : dec_cw.cls == C_HALT ? HALT : EXEC;
        EXEC: begin
          case (cw_q.cls)
            C_BEQ, C_BNE: begin
              PC_EN = (cw_q.cls == C_BEQ) == zero;
              PC_src = PC_EN ? 2'b01 : 2'b00;
              nxt = FETCH;
            end
            C_J:  begin PC_EN = 1'b1; PC_src = 2'b10; nxt = FETCH; end
            C_JR: begin PC_EN = 1'b1; PC_src = 2'b11; nxt = FETCH; end
            C_JAL: begin
              PC_EN = 1'b1;
              PC_src = 2'b10;
              RegWrite = 1'b1;
              RegDst = 2'b10;
              MemtoReg = 2'b10;
              nxt = FETCH;
            end
            C_LW, C_SW, C_LL, C_SC: nxt = MEM;
            default: nxt = WB;
          endcase
        end
        MEM: begin
          dREN = cw_q.cls inside {C_LW, C_LL};
          dWEN = cw_q.cls inside {C_SW, C_SC};
          datomic = cw_q.cls inside {C_LL, C_SC};
          nxt = dhit ? (cw_q.cls == C_SW ? FETCH : WB) : timeout ? ERR : MEM;
        end
        WB: begin
          RegWrite = !trap;
          exc = trap;
          RegDst = cw_q.rtype ? 2'b00 : 2'b01;
          MemtoReg = cw_q.cls inside {C_LW, C_LL, C_SC} ? 2'b01 : 2'b00;
          nxt = FETCH;
        end
        default: nxt = cur;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed checks of two parameterisations driven in lockstep
module tb_multicycle_control_fsm;
  import cpu_types_pkg::*;
  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_BEQ  = {6'b000100, 26'd0};
  localparam logic [31:0] I_BNE  = {6'b000101, 26'd0};
  localparam logic [31:0] I_LW   = {6'b100011, 26'd0};
  localparam logic [31:0] I_SW   = {6'b101011, 26'd0};
  localparam logic [31:0] I_LL   = {6'b110000, 26'd0};
  localparam logic [31:0] I_HALT = {6'b111111, 26'd0};
  localparam logic [31:0] I_BAD  = {6'b010000, 26'd0};
  logic CLK = 1'b0, RST = 1'b1, ihit = 1'b0, dhit = 1'b0, zero = 1'b0, overflow = 1'b0;
  logic [31:0] instr = '0;
  logic [1:0] PC_src, portb_src, RegDst, MemtoReg, PC_src_b, portb_src_b, RegDst_b, MemtoReg_b;
  logic PC_EN, IR_EN, Ext_src, LUI_src, iREN, dREN, dWEN, datomic, RegWrite, check_over, exc, halt, err;
  logic PC_EN_b, IR_EN_b, Ext_src_b, LUI_src_b, iREN_b, dREN_b, dWEN_b, datomic_b, RegWrite_b, check_over_b, exc_b, halt_b, err_b;
  logic [2:0] state, state_b;
  aluop_t ALU_op, ALU_op_b;
  int checks = 0, errors = 0;
  multicycle_control_fsm #(.MEM_TIMEOUT(4), .ATOMIC_EN(1), .OVF_TRAP(1)) dut (
    .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero), .overflow(overflow),
    .PC_src(PC_src), .PC_EN(PC_EN), .IR_EN(IR_EN), .Ext_src(Ext_src), .LUI_src(LUI_src),
    .portb_src(portb_src), .RegDst(RegDst), .ALU_op(ALU_op), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .datomic(datomic), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .check_over(check_over), .exc(exc),
    .halt(halt), .err(err), .state(state)
  );
  multicycle_control_fsm #(.MEM_TIMEOUT(8), .ATOMIC_EN(0), .OVF_TRAP(0)) dut_b (
    .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero), .overflow(overflow),
    .PC_src(PC_src_b), .PC_EN(PC_EN_b), .IR_EN(IR_EN_b), .Ext_src(Ext_src_b), .LUI_src(LUI_src_b),
    .portb_src(portb_src_b), .RegDst(RegDst_b), .ALU_op(ALU_op_b), .iREN(iREN_b), .dREN(dREN_b), .dWEN(dWEN_b),
    .datomic(datomic_b), .MemtoReg(MemtoReg_b), .RegWrite(RegWrite_b), .check_over(check_over_b), .exc(exc_b),
    .halt(halt_b), .err(err_b), .state(state_b)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic fetch_decode(input logic [31:0] w);
    instr = w;
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    tick();
  endtask
  initial begin
    #2;
    chk("rst_iren", iREN, 0);
    chk("rst_state", state, 0);
    chk("rst_iren_en", IR_EN, 0);
    chk("rst_err", err, 0);
    tick();
    RST = 1'b0;
    instr = I_ADDU;
    #1;
    chk("addu_f1_iren", iREN, 1);
    chk("addu_f1_ir_en", IR_EN, 0);
    tick();
    ihit = 1'b1;
    #1;
    chk("addu_f2_ir_en", IR_EN, 1);
    chk("addu_f2_pc_en", PC_EN, 1);
    chk("addu_f2_pc_src", PC_src, 0);
    tick();
    ihit = 1'b0;
    #1;
    chk("addu_decode", state, 1);
    tick();
    ihit = 1'b1;
    #1;
    chk("addu_exec", state, 2);
    chk("addu_exec_ihit_ignored", IR_EN, 0);
    chk("addu_alu_op", ALU_op, ALU_ADD);
    chk("addu_exec_pc_en", PC_EN, 0);
    ihit = 1'b0;
    tick();
    #1;
    chk("addu_wb", state, 4);
    chk("addu_wb_regwrite", RegWrite, 1);
    chk("addu_wb_regdst", RegDst, 0);
    chk("addu_wb_memtoreg", MemtoReg, 0);
    tick();
    #1;
    chk("addu_back_fetch", state, 0);
    fetch_decode(I_BEQ);
    zero = 1'b1;
    #1;
    chk("beq_pc_en", PC_EN, 1);
    chk("beq_pc_src", PC_src, 1);
    tick();
    #1;
    chk("beq_fetch", state, 0);
    fetch_decode(I_BNE);
    #1;
    chk("bne_pc_en", PC_EN, 0);
    tick();
    zero = 1'b0;
    #1;
    chk("bne_fetch", state, 0);
    fetch_decode(I_LW);
    #1;
    chk("lw_exec", state, 2);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_dren", dREN, 1);
      chk("lw_wait_state", state, 3);
      tick();
    end
    dhit = 1'b1;
    #1;
    chk("lw_hit_at_limit_dren", dREN, 1);
    tick();
    dhit = 1'b0;
    #1;
    chk("lw_wb", state, 4);
    chk("lw_memtoreg", MemtoReg, 1);
    chk("lw_regdst", RegDst, 1);
    chk("lw_regwrite", RegWrite, 1);
    tick();
    fetch_decode(I_SW);
    tick();
    dhit = 1'b1;
    #1;
    chk("sw_dwen", dWEN, 1);
    chk("sw_dren", dREN, 0);
    chk("sw_datomic", datomic, 0);
    tick();
    dhit = 1'b0;
    #1;
    chk("sw_no_wb", state, 0);
    fetch_decode(I_ADD);
    #1;
    chk("add_check_over", check_over, 1);
    tick();
    overflow = 1'b1;
    #1;
    chk("ovf_trap_regwrite", RegWrite, 0);
    chk("ovf_trap_exc", exc, 1);
    chk("ovf_notrap_regwrite", RegWrite_b, 1);
    chk("ovf_notrap_exc", exc_b, 0);
    tick();
    overflow = 1'b0;
    #1;
    chk("ovf_exc_pulse_end", exc, 0);
    chk("ovf_fetch", state, 0);
    fetch_decode(I_LL);
    #1;
    chk("ll_exec", state, 2);
    chk("ll_noatomic_err_state", state_b, 6);
    chk("ll_noatomic_err", err_b, 1);
    tick();
    #1;
    chk("ll_dren", dREN, 1);
    chk("ll_datomic", datomic, 1);
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    #1;
    chk("ll_wb_memtoreg", MemtoReg, 1);
    tick();
    fetch_decode(I_HALT);
    #1;
    chk("halt_flag", halt, 1);
    chk("halt_state", state, 5);
    chk("halt_iren", iREN, 0);
    ihit = 1'b1;
    #1;
    chk("halt_ihit_ignored", IR_EN, 0);
    tick();
    tick();
    #1;
    chk("halt_sticky", halt, 1);
    chk("halt_iren_later", iREN, 0);
    ihit = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_clears_halt", halt, 0);
    chk("rst_clears_err_b", err_b, 0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("timeout_not_yet", err, 0);
      tick();
    end
    #1;
    chk("timeout_err", err, 1);
    chk("timeout_state", state, 6);
    chk("timeout_longer_limit", err_b, 0);
    repeat (3) tick();
    #1;
    chk("timeout_err_sticky", err, 1);
    RST = 1'b1;
    #1;
    chk("async_rst_err", err, 0);
    chk("async_rst_iren", iREN, 0);
    tick();
    RST = 1'b0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_iren", iREN, 1);
    fetch_decode(I_BAD);
    #1;
    chk("illegal_op_state", state, 6);
    chk("illegal_op_err", err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
